// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, exponent limits and the packed operand view
// used by the floating-point multiplier.
package fp32_pkg;

    localparam int FP_EXP_W   = 8;
    localparam int FP_FRAC_W  = 23;
    localparam int FP_MANT_W  = FP_FRAC_W + 1;
    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 254;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/floating_point_multiplier_if.sv
// Operand/result bundle for the multiplier. There is no handshake: the
// master drives a/b every cycle and the slave registers a product every edge.
interface floating_point_multiplier_if;

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        overflow;

    modport master (output a, output b, input result, input overflow);
    modport slave  (input a, input b, output result, output overflow);

endinterface

// File: rtl/fp_mant_mul.sv
// Combinational 24x24 unsigned significand multiplier, kept separate so a
// faster or pipelined implementation can be dropped in.
module fp_mant_mul
    import fp32_pkg::*;
(
    input  logic [FP_MANT_W-1:0]   mant_a,
    input  logic [FP_MANT_W-1:0]   mant_b,
    output logic [2*FP_MANT_W-1:0] prod
);

    assign prod = mant_a * mant_b;

endmodule

// File: rtl/floating_point_multiplier.sv
// Binary32 multiplier: flush-to-zero inputs, truncated fraction, wrapped
// exponent field with an out-of-range flag, one output register.
module floating_point_multiplier
    import fp32_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    floating_point_multiplier_if.slave  bus
);

    localparam logic signed [9:0] BIAS_S    = 10'(FP_BIAS);
    localparam logic signed [9:0] EXP_MAX_S = 10'(FP_EXP_MAX);

    fp32_t                    op_a;
    fp32_t                    op_b;
    logic [FP_MANT_W-1:0]     mant_a;
    logic [FP_MANT_W-1:0]     mant_b;
    logic [2*FP_MANT_W-1:0]   prod;
    logic signed [9:0]        exp_sum;
    logic signed [9:0]        exp_norm;
    logic [FP_FRAC_W-1:0]     frac_norm;
    logic                     sign;
    logic                     is_zero;
    logic                     ovf_d;
    logic [31:0]              result_d;
    logic                     unused_low_bits;

    assign op_a   = bus.a;
    assign op_b   = bus.b;
    assign mant_a = {1'b1, op_a.frac};
    assign mant_b = {1'b1, op_b.frac};

    fp_mant_mul u_mant_mul (
        .mant_a (mant_a),
        .mant_b (mant_b),
        .prod   (prod)
    );

    // Truncation: product bits below the kept fraction are dropped.
    assign unused_low_bits = ^prod[FP_FRAC_W-1:0];

    always_comb begin
        sign     = op_a.sign ^ op_b.sign;
        is_zero  = (op_a.exp == '0) || (op_b.exp == '0);
        exp_sum  = signed'({2'b00, op_a.exp}) + signed'({2'b00, op_b.exp}) - BIAS_S;
        exp_norm = exp_sum;
        frac_norm = prod[45:23];
        if (prod[47]) begin
            frac_norm = prod[46:24];
            exp_norm  = exp_sum + 10'sd1;
        end
        ovf_d    = (exp_norm > EXP_MAX_S) || (exp_norm < 10'sd1);
        // Exponent field wraps modulo 256 even when flagged; no saturation.
        result_d = {sign, exp_norm[7:0], frac_norm};
        if (is_zero) begin
            ovf_d    = 1'b0;
            result_d = {sign, 31'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result   <= 32'h0000_0000;
            bus.overflow <= 1'b0;
        end else begin
            bus.result   <= result_d;
            bus.overflow <= ovf_d;
        end
    end

endmodule

// File: tb/tb_floating_point_multiplier.sv
// Directed-vector bench for the binary32 multiplier: reset, arithmetic cases,
// exponent boundaries, async reset mid-cycle and back-to-back operands.
module tb_floating_point_multiplier;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    floating_point_multiplier_if bus ();

    floating_point_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        bus.a = va;
        bus.b = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] exp_r, input logic exp_o);
        n_vec++;
        assert (bus.result === exp_r) else begin
            n_fail++;
            $error("FAIL %s result got %h expected %h", tag, bus.result, exp_r);
        end
        n_vec++;
        assert (bus.overflow === exp_o) else begin
            n_fail++;
            $error("FAIL %s overflow got %b expected %b", tag, bus.overflow, exp_o);
        end
    endtask

    logic [31:0] b2b_a [4];
    logic [31:0] b2b_b [4];
    logic [31:0] b2b_r [4];
    logic        b2b_o [4];

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.a  = 32'h408a2000;
        bus.b  = 32'hc08a2000;

        // Reset holds outputs at zero across edges even with live operands.
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 32'h00000000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(32'h408a2000, 32'hc08a2000); check("sign_exact",   32'hc1950d08, 1'b0);
        apply(32'h408aa000, 32'h408a2000); check("pos_pos",      32'h41959728, 1'b0);
        apply(32'hc28aa000, 32'hc10a2000); check("neg_neg",      32'h44159728, 1'b0);
        apply(32'hc28aa000, 32'h418aa000); check("neg_pos",      32'hc49621c8, 1'b0);
        apply(32'h00000000, 32'h418aa000); check("zero",         32'h00000000, 1'b0);
        apply(32'h3f800000, 32'h418aa000); check("identity",     32'h418aa000, 1'b0);
        apply(32'hb9807000, 32'h418aa000); check("small_exp",    32'hbb8b194c, 1'b0);
        apply(32'h79807000, 32'h518aa000); check("ovf_wrap",     32'h0b8b194c, 1'b1);
        apply(32'h3fc00000, 32'h3fc00000); check("norm_carry",   32'h40100000, 1'b0);
        apply(32'h00400000, 32'h3f800000); check("denorm_flush", 32'h00000000, 1'b0);
        apply(32'h80000000, 32'h3f800000); check("neg_zero",     32'h80000000, 1'b0);
        apply(32'h7f000000, 32'h3f800000); check("exp_254",      32'h7f000000, 1'b0);
        apply(32'h7f800000, 32'h3f800000); check("exp_255_inf",  32'h7f800000, 1'b1);
        apply(32'h00800000, 32'h3f800000); check("exp_1",        32'h00800000, 1'b0);
        apply(32'h00800000, 32'h00800000); check("underflow",    32'h41800000, 1'b1);

        // Operand change between edges must not reach the outputs.
        apply(32'h408a2000, 32'hc08a2000); check("pre_midchg",   32'hc1950d08, 1'b0);
        #1;
        bus.a = 32'h3f800000;
        bus.b = 32'h418aa000;
        #1;
        check("mid_change_held", 32'hc1950d08, 1'b0);
        @(posedge clk);
        #1;
        check("mid_change_next", 32'h418aa000, 1'b0);

        // Asynchronous reset between edges while outputs are non-zero.
        apply(32'hc28aa000, 32'h418aa000); check("pre_reset",    32'hc49621c8, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", 32'h00000000, 1'b0);
        @(posedge clk);
        #1;
        check("async_reset_held", 32'h00000000, 1'b0);
        @(negedge clk);
        bus.a = 32'hb9807000;
        bus.b = 32'h418aa000;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_capture", 32'hbb8b194c, 1'b0);

        // Back-to-back: new operands every cycle, each result one edge later.
        b2b_a[0] = 32'h408aa000; b2b_b[0] = 32'h408a2000; b2b_r[0] = 32'h41959728; b2b_o[0] = 1'b0;
        b2b_a[1] = 32'h79807000; b2b_b[1] = 32'h518aa000; b2b_r[1] = 32'h0b8b194c; b2b_o[1] = 1'b1;
        b2b_a[2] = 32'hc28aa000; b2b_b[2] = 32'hc10a2000; b2b_r[2] = 32'h44159728; b2b_o[2] = 1'b0;
        b2b_a[3] = 32'h00000000; b2b_b[3] = 32'hc10a2000; b2b_r[3] = 32'h80000000; b2b_o[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(b2b_a[i], b2b_b[i]);
            check($sformatf("b2b_%0d", i), b2b_r[i], b2b_o[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
